reaction_timer_ctrl: RTL and testbench
======================================

# reaction_timer_ctrl

Sequencing controller for the reaction-time game. It samples the free-running random counter to pick a pseudo-random delay, waits that long, then lights the stimulus LED and measures in milliseconds how long the player takes to press stop. It detects early presses ("cheat") and no-response timeouts. It sits between the button synchronizers, the random counter and the display logic, and runs on the 1 kHz millisecond clock.

## Interface
Parameters:
- MIN_DELAY, default 1000: fixed part of the pre-stimulus delay, in ms.
- MAX_RESULT, default 9999: reaction count at which the measurement times out, in ms.

Ports:
- ms_clk, input, 1: 1 kHz clock; one cycle is 1 ms. This is the only clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: start button, already synchronized, level.
- stop, input, 1: stop/react button, already synchronized, level.
- rnd_cnt, input, 11: current value of the random counter.
- led, output, 1: stimulus LED.
- busy, output, 1: high while in WAIT or REACT.
- result, output, 14: measured reaction time in ms.
- result_valid, output, 1: high in DONE.
- cheat, output, 1: high in CHEAT.
- timeout, output, 1: high in DONE when the measurement saturated.

## Operation
- Edge detection uses registers start_q and stop_q.
  - A start edge is start=1 && start_q=0. A stop edge is stop=1 && stop_q=0.
  - Both registers load their input every cycle, including during reset, so a button held through reset does not produce an edge.
- States are IDLE, WAIT, REACT, DONE and CHEAT. Reset forces IDLE.
- IDLE:
  - A start edge moves to WAIT and loads delay_cnt = MIN_DELAY + rnd_cnt.
  - rnd_cnt is sampled in the edge cycle. The sum is 12 bits wide, so no overflow is possible (max 3047 at default).
- WAIT:
  - delay_cnt decrements every cycle.
  - When delay_cnt==1 the next state is REACT, with led set to 1 and react_cnt set to 0.
  - A stop edge in WAIT goes to CHEAT instead, and takes priority over expiry in the same cycle.
- REACT:
  - On a stop edge, result is loaded with react_cnt and the next state is DONE.
  - Otherwise, if react_cnt==MAX_RESULT, result is loaded with MAX_RESULT, timeout is set to 1 and the next state is DONE.
  - Otherwise react_cnt increments. A stop edge in the first REACT cycle therefore gives result=0.
- DONE: holds result. A start edge clears result_valid and timeout and moves to WAIT, reloading the delay exactly as IDLE does.
- CHEAT: result=0 and led=0. A start edge restarts exactly as from DONE.
- Simultaneous start and stop edges:
  - In IDLE, DONE and CHEAT, start wins and stop is ignored.
  - In WAIT and REACT, stop wins and start is ignored.
- Stop edges in IDLE, DONE and CHEAT are ignored. Start edges in WAIT and REACT are ignored.
- Outputs are registered and decoded from state:
  - led is 1 only in REACT.
  - busy is 1 in WAIT and REACT.
  - result_valid is 1 in DONE.
  - cheat is 1 in CHEAT.
- The react counter is 14 bits and never exceeds MAX_RESULT.

## Timing
- Reset values: led=0, busy=0, result=0, result_valid=0, cheat=0, timeout=0, state IDLE, delay_cnt=0, react_cnt=0.
- A reset asserted mid-operation takes effect at the next posedge from any state and clears all of the above. An in-flight result is discarded.
- Let posedge t be the edge that samples the start edge and D = MIN_DELAY + rnd_cnt at t.
  - busy=1 after posedge t.
  - led=1 after posedge t+D, so WAIT lasts exactly D cycles.
- Let the stop edge be sampled at posedge s, with the LED rising at posedge r. Then result = s-r-1, and result_valid, with led=0, follows posedge s.
- Timeout: with no stop edge, DONE is entered after posedge r+MAX_RESULT+1, with result=MAX_RESULT and timeout=1.
- Early press: if the stop edge is at posedge s with t<s≤t+D, then cheat=1, busy=0 and led=0 after posedge s, and led never rises.

## Test plan
- Reset and held buttons: start=1 held through reset, then reset released → no transition. Outputs stay 0 until start falls and rises again.
- Normal round (MIN_DELAY=5, rnd_cnt=3): start edge at t → led rises after t+8. Stop edge 4 cycles after the led posedge → result=3, result_valid=1, led=0, busy=0.
- Cheat: stop edge at t+4 (WAIT) → cheat=1, result=0, led never rises. A start edge then re-enters WAIT with cheat=0.
- Timeout (MAX_RESULT=20): no stop → DONE after r+21, result=20, timeout=1.
- Boundary stops:
  - Stop edge at posedge t+8, the WAIT expiry cycle → CHEAT.
  - Stop edge at the first REACT cycle → result=0.
  - Simultaneous start and stop edges in IDLE → WAIT entered.
- Reset mid-REACT: reset at r+2 → next posedge IDLE, all outputs 0. A later round measures correctly.

Source files
------------

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game sequencer: random pre-stimulus delay, LED stimulus,
// millisecond reaction measurement with cheat and no-response detection.
module reaction_timer_ctrl #(
    parameter int unsigned MIN_DELAY  = 1000,
    parameter int unsigned MAX_RESULT = 9999
) (
    input  logic        ms_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [10:0] rnd_cnt,
    output logic        led,
    output logic        busy,
    output logic [13:0] result,
    output logic        result_valid,
    output logic        cheat,
    output logic        timeout
);

    localparam int unsigned DELAY_W = 12;
    localparam int unsigned REACT_W = 14;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        REACT,
        DONE,
        CHEAT
    } state_t;

    state_t               state;
    logic                 start_q;
    logic                 stop_q;
    logic [DELAY_W-1:0]   delay_cnt;
    logic [REACT_W-1:0]   react_cnt;
    logic                 start_edge;
    logic                 stop_edge;
    logic [DELAY_W-1:0]   delay_load;

    assign start_edge = start & ~start_q;
    assign stop_edge  = stop & ~stop_q;
    assign delay_load = DELAY_W'(MIN_DELAY) + DELAY_W'(rnd_cnt);

    // Button history loads even during reset so a held button gives no edge.
    always_ff @(posedge ms_clk) begin
        start_q <= start;
        stop_q  <= stop;
        if (reset) begin
            state        <= IDLE;
            delay_cnt    <= '0;
            react_cnt    <= '0;
            led          <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            cheat        <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, CHEAT: begin
                    if (start_edge) begin
                        state        <= WAIT;
                        delay_cnt    <= delay_load;
                        led          <= 1'b0;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        cheat        <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end
                WAIT: begin
                    if (stop_edge) begin
                        state  <= CHEAT;
                        led    <= 1'b0;
                        busy   <= 1'b0;
                        cheat  <= 1'b1;
                        result <= '0;
                    end else begin
                        delay_cnt <= delay_cnt - DELAY_W'(1);
                        if (delay_cnt == DELAY_W'(1)) begin
                            state     <= REACT;
                            led       <= 1'b1;
                            react_cnt <= '0;
                        end
                    end
                end
                REACT: begin
                    if (stop_edge) begin
                        state        <= DONE;
                        result       <= react_cnt;
                        led          <= 1'b0;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                    end else if (react_cnt == REACT_W'(MAX_RESULT)) begin
                        state        <= DONE;
                        result       <= REACT_W'(MAX_RESULT);
                        led          <= 1'b0;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        timeout      <= 1'b1;
                    end else begin
                        react_cnt <= react_cnt + REACT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: scoreboard of round outcomes plus direct timing checks.
module tb_reaction_timer_ctrl;

    localparam int unsigned MIN_D = 5;
    localparam int unsigned MAX_R = 20;

    typedef struct {
        logic [13:0] res;
        logic        tmo;
        logic        cht;
    } exp_t;

    logic        ms_clk = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic        stop   = 1'b0;
    logic [10:0] rnd_cnt = '0;
    logic        led;
    logic        busy;
    logic [13:0] result;
    logic        result_valid;
    logic        cheat;
    logic        timeout;

    int   total = 0;
    int   bad   = 0;
    exp_t sbq[$];

    reaction_timer_ctrl #(.MIN_DELAY(MIN_D), .MAX_RESULT(MAX_R)) dut (
        .ms_clk      (ms_clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .rnd_cnt     (rnd_cnt),
        .led         (led),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .cheat       (cheat),
        .timeout     (timeout)
    );

    always #5 ms_clk = ~ms_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ms_clk);
        #1;
    endtask

    // Start edge sampled at the next posedge (t); returns at t+1ns.
    task automatic start_round(input logic [10:0] rnd);
        rnd_cnt = rnd;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_led", led, 0);
    endtask

    task automatic wait_led(output int n);
        n = 0;
        while (led !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
    endtask

    // Stop edge sampled n cycles after the current posedge; expectation pushed first.
    task automatic press_after(input int n, input exp_t e);
        for (int i = 0; i < n - 1; i++) tick();
        stop = 1'b1;
        sbq.push_back(e);
        tick();
        stop = 1'b0;
    endtask

    // Scoreboard side: every new result_valid or cheat pulse consumes one expectation.
    logic prev_rv = 1'b0;
    logic prev_ch = 1'b0;
    always @(posedge ms_clk) begin
        exp_t e;
        #1;
        if ((result_valid === 1'b1 && prev_rv !== 1'b1) || (cheat === 1'b1 && prev_ch !== 1'b1)) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_timeout", timeout, e.tmo);
                chk("sb_cheat", cheat, e.cht);
                chk("sb_valid", result_valid, !e.cht);
            end
        end
        prev_rv = result_valid;
        prev_ch = cheat;
    end

    initial begin
        int n;
        int led_seen;

        // Start held through reset produces no edge
        start = 1'b1;
        repeat (3) tick();
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_cheat", cheat, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b0;
        repeat (4) tick();
        chk("held_busy", busy, 0);
        start = 1'b0;
        tick();
        chk("released_busy", busy, 0);

        // Normal round: D=8, stop 4 cycles after LED rise -> 3
        start_round(11'd3);
        wait_led(n);
        chk("normal_delay", n, 8);
        press_after(4, '{res: 14'd3, tmo: 1'b0, cht: 1'b0});
        chk("normal_led_off", led, 0);
        chk("normal_busy", busy, 0);

        // Early press in WAIT
        start_round(11'd3);
        press_after(4, '{res: 14'd0, tmo: 1'b0, cht: 1'b1});
        chk("cheat_busy", busy, 0);
        chk("cheat_led", led, 0);
        led_seen = 0;
        repeat (12) begin
            tick();
            if (led === 1'b1) led_seen = 1;
        end
        chk("cheat_led_never", led_seen, 0);
        start_round(11'd0);
        chk("restart_cheat_clr", cheat, 0);

        // Timeout with D=5
        wait_led(n);
        chk("timeout_delay", n, 5);
        sbq.push_back('{res: 14'(MAX_R), tmo: 1'b1, cht: 1'b0});
        n = 0;
        while (result_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, MAX_R + 1);
        chk("timeout_led", led, 0);

        // Stop in the WAIT expiry cycle is still a cheat
        start_round(11'd3);
        press_after(8, '{res: 14'd0, tmo: 1'b0, cht: 1'b1});
        chk("expiry_led", led, 0);
        chk("expiry_cheat", cheat, 1);

        // Stop in the first REACT cycle
        start_round(11'd3);
        wait_led(n);
        chk("first_delay", n, 8);
        press_after(1, '{res: 14'd0, tmo: 1'b0, cht: 1'b0});

        // Reset mid-REACT discards the round
        start_round(11'd2);
        wait_led(n);
        chk("mid_delay", n, 7);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_led", led, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_valid", result_valid, 0);

        // Simultaneous start and stop in IDLE: start wins
        rnd_cnt = 11'd3;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("simul_busy", busy, 1);
        chk("simul_cheat", cheat, 0);
        wait_led(n);
        chk("after_rst_delay", n, 8);
        press_after(5, '{res: 14'd4, tmo: 1'b0, cht: 1'b0});
        repeat (2) tick();

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
